// File: rtl/npu_mem_arbiter.sv
// npu_mem_arbiter
//   Shares one single-port DATA_W-bit memory between three requesters:
//   compute (C), host/pico bridge (H) and sequencer fetch (S).
//   Fixed priority C > H > S. H or S is promoted above everything once it has
//   waited STARVE_MAX cycles with req held. The winning command is registered
//   onto mem_*. Each read is tagged with its owner so that rdata returns with
//   a one-cycle per-port rvalid pulse RD_LAT cycles after the grant.
//
// Ports
//   clock, reset          posedge clock, synchronous active-high reset
//   {c,h,s}_req           request, held with wen/addr/wdata until gnt
//   {c,h,s}_wen           byte write enables; all-zero means read
//   {c,h,s}_addr/_wdata   word address / write data
//   {c,h,s}_gnt           combinational grant, at most one per cycle
//   {c,h,s}_rvalid        rdata carries this port's read result
//   rdata                 shared read data (passthrough of mem_rdata)
//   busy                  a read is in flight or any req is high
//   mem_addr/wen/wdata    registered memory command
//   mem_rdata             memory read data, RD_LAT-1 cycles after mem_addr

// Wait counter for one promotable requester. It counts cycles spent waiting
// with req high, saturates at STARVE_MAX, and clears on grant or when req drops.
module npu_mem_arbiter_starve #(
   parameter int STARVE_MAX = 8
) (
   input  logic clock,
   input  logic reset,
   input  logic req,
   input  logic gnt,
   output logic starved
);
   localparam int CW = $clog2(STARVE_MAX + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clock) begin
      if (reset || !req || gnt)
         cnt <= '0;
      else if (cnt != CW'(STARVE_MAX))
         cnt <= cnt + CW'(1);
   end

   assign starved = req && (cnt == CW'(STARVE_MAX));
endmodule

module npu_mem_arbiter #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 64,
   parameter int RD_LAT     = 2,
   parameter int STARVE_MAX = 8
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                c_req,
   input  logic [DATA_W/8-1:0] c_wen,
   input  logic [ADDR_W-1:0]   c_addr,
   input  logic [DATA_W-1:0]   c_wdata,
   output logic                c_gnt,
   output logic                c_rvalid,
   input  logic                h_req,
   input  logic [DATA_W/8-1:0] h_wen,
   input  logic [ADDR_W-1:0]   h_addr,
   input  logic [DATA_W-1:0]   h_wdata,
   output logic                h_gnt,
   output logic                h_rvalid,
   input  logic                s_req,
   input  logic [DATA_W/8-1:0] s_wen,
   input  logic [ADDR_W-1:0]   s_addr,
   input  logic [DATA_W-1:0]   s_wdata,
   output logic                s_gnt,
   output logic                s_rvalid,
   output logic [DATA_W-1:0]   rdata,
   output logic                busy,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W/8-1:0] mem_wen,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata
);
   localparam int BE_W = DATA_W / 8;
   localparam int NP   = 3;          // index 0 = C, 1 = H, 2 = S

   logic [NP-1:0]             req;
   logic [NP-1:0][BE_W-1:0]   wen;
   logic [NP-1:0][ADDR_W-1:0] addr;
   logic [NP-1:0][DATA_W-1:0] wdata;
   logic [NP-1:0]             arb_gnt;
   logic [NP-1:0]             starved;

   assign req   = {s_req, h_req, c_req};
   assign wen   = {s_wen, h_wen, c_wen};
   assign addr  = {s_addr, h_addr, c_addr};
   assign wdata = {s_wdata, h_wdata, c_wdata};

   // C is top of the fixed order and never needs promotion.
   assign starved[0] = 1'b0;

   for (genvar i = 1; i < NP; i++) begin : g_starve
      npu_mem_arbiter_starve #(.STARVE_MAX(STARVE_MAX)) u_starve (
         .clock   (clock),
         .reset   (reset),
         .req     (req[i]),
         .gnt     (arb_gnt[i]),
         .starved (starved[i])
      );
   end

   // Starved H beats starved S; both beat the fixed order. Nothing is
   // granted while reset is high.
   always_comb begin
      arb_gnt = '0;
      if (!reset) begin
         if (starved[1])      arb_gnt[1] = 1'b1;
         else if (starved[2]) arb_gnt[2] = 1'b1;
         else if (req[0])     arb_gnt[0] = 1'b1;
         else if (req[1])     arb_gnt[1] = 1'b1;
         else if (req[2])     arb_gnt[2] = 1'b1;
      end
   end

   // One-hot grant selects the winner's command.
   logic [BE_W-1:0]   win_wen;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;
   logic [1:0]        win_own;

   always_comb begin
      win_wen   = '0;
      win_addr  = '0;
      win_wdata = '0;
      win_own   = '0;
      for (int i = 0; i < NP; i++) begin
         if (arb_gnt[i]) begin
            win_wen   = wen[i];
            win_addr  = addr[i];
            win_wdata = wdata[i];
            win_own   = 2'(i);
         end
      end
   end

   logic rd_gnt;
   assign rd_gnt = (|arb_gnt) && (win_wen == '0);

   // Read tags: stage k holds reads granted k+1 cycles ago, so the last
   // stage lines up with mem_rdata for the oldest outstanding read.
   logic [RD_LAT-1:0]      vld_pipe;
   logic [RD_LAT-1:0][1:0] own_pipe;

   always_ff @(posedge clock) begin
      if (reset) begin
         mem_addr  <= '0;
         mem_wen   <= '0;
         mem_wdata <= '0;
         vld_pipe  <= '0;
         own_pipe  <= '0;
      end else begin
         if (|arb_gnt) begin
            mem_addr  <= win_addr;
            mem_wen   <= win_wen;
            mem_wdata <= win_wdata;
         end else begin
            mem_wen   <= '0;
         end
         vld_pipe <= {vld_pipe[RD_LAT-2:0], rd_gnt};
         own_pipe <= {own_pipe[RD_LAT-2:0], win_own};
      end
   end

   assign c_gnt = arb_gnt[0];
   assign h_gnt = arb_gnt[1];
   assign s_gnt = arb_gnt[2];

   assign c_rvalid = vld_pipe[RD_LAT-1] && (own_pipe[RD_LAT-1] == 2'd0);
   assign h_rvalid = vld_pipe[RD_LAT-1] && (own_pipe[RD_LAT-1] == 2'd1);
   assign s_rvalid = vld_pipe[RD_LAT-1] && (own_pipe[RD_LAT-1] == 2'd2);

   assign rdata = mem_rdata;
   assign busy  = (|vld_pipe) || (|req);
endmodule

// File: tb/tb_npu_mem_arbiter.sv
// Bench for npu_mem_arbiter: directed table, hand sequences for the
// multi-cycle corners, then random traffic against a reference model that
// runs continuously from the DUT's input pins.
module tb_npu_mem_arbiter;
   localparam int RD_LAT = 2;
   localparam int STARVE = 8;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   // Port index: 0 = C, 1 = H, 2 = S
   logic [2:0]        req = '0;
   logic [2:0][7:0]   wen = '0;
   logic [2:0][15:0]  addr = '0;
   logic [2:0][63:0]  wdata = '0;

   logic c_gnt, h_gnt, s_gnt, c_rvalid, h_rvalid, s_rvalid, busy;
   logic [63:0] rdata, mem_wdata, mem_rdata;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wen;
   logic [2:0]  gnt, rv;
   assign gnt = {s_gnt, h_gnt, c_gnt};
   assign rv  = {s_rvalid, h_rvalid, c_rvalid};

   npu_mem_arbiter #(.ADDR_W(16), .DATA_W(64), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE)) dut (
      .clock(clock), .reset(reset),
      .c_req(req[0]), .c_wen(wen[0]), .c_addr(addr[0]), .c_wdata(wdata[0]),
      .c_gnt(c_gnt), .c_rvalid(c_rvalid),
      .h_req(req[1]), .h_wen(wen[1]), .h_addr(addr[1]), .h_wdata(wdata[1]),
      .h_gnt(h_gnt), .h_rvalid(h_rvalid),
      .s_req(req[2]), .s_wen(wen[2]), .s_addr(addr[2]), .s_wdata(wdata[2]),
      .s_gnt(s_gnt), .s_rvalid(s_rvalid),
      .rdata(rdata), .busy(busy),
      .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] fill(input int a);
      logic [15:0] aa;
      aa = 16'(a);
      if (a == 16'h0010) return 64'h1122334455667788;
      return {16'hF00D, aa, ~aa, aa};
   endfunction

   function automatic logic [63:0] merge(input logic [63:0] old, input logic [7:0] be,
                                         input logic [63:0] d);
      logic [63:0] r;
      r = old;
      for (int b = 0; b < 8; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
      return r;
   endfunction

   // Memory: write-first, rdata one cycle after the address.
   logic [63:0] mem    [0:65535];
   logic [63:0] shadow [0:65535];
   initial for (int i = 0; i < 65536; i++) begin mem[i] = fill(i); shadow[i] = fill(i); end

   always @(posedge clock) begin
      if (mem_wen != 8'h00) mem[mem_addr] <= merge(mem[mem_addr], mem_wen, mem_wdata);
      mem_rdata <= merge(mem[mem_addr], mem_wen, mem_wdata);
   end

   // ---------------- reference model ----------------
   typedef struct { int due; int own; logic [63:0] data; } rd_t;
   rd_t rdq[$];
   int  cyc = 0;
   bit  armed = 0;
   int  wait_h = 0, wait_s = 0;     // consecutive cycles waited with req high
   logic [7:0]  exp_wen = '0;
   logic [15:0] exp_addr = '0;
   logic [63:0] exp_wdata = '0;

   always @(negedge clock) begin
      int win;
      logic [2:0]  exp_rv;
      logic [63:0] exp_rd;
      rd_t e;
      win = -1;
      if (armed) begin
         chk("busy", busy, 64'((rdq.size() != 0) || (req != 3'b000)));
         exp_rv = '0;
         exp_rd = '0;
         if (rdq.size() != 0 && rdq[0].due == cyc) begin
            exp_rv[rdq[0].own] = 1'b1;
            exp_rd = rdq[0].data;
            void'(rdq.pop_front());
         end
         chk("rvalid", rv, exp_rv);
         if (exp_rv != 3'b000) chk("rdata", rdata, exp_rd);
         chk("mem_wen", mem_wen, exp_wen);
         chk("mem_addr", mem_addr, exp_addr);
         chk("mem_wdata", mem_wdata, exp_wdata);

         if (!reset) begin
            if (req[1] && wait_h >= STARVE)      win = 1;
            else if (req[2] && wait_s >= STARVE) win = 2;
            else if (req[0])                     win = 0;
            else if (req[1])                     win = 1;
            else if (req[2])                     win = 2;
         end
         chk("gnt", gnt, (win >= 0) ? 64'(3'b001 << win) : 64'd0);

         if (win >= 0) begin
            exp_wen   = wen[win];
            exp_addr  = addr[win];
            exp_wdata = wdata[win];
            if (wen[win] == 8'h00) begin
               e.due  = cyc + RD_LAT;
               e.own  = win;
               e.data = shadow[addr[win]];
               rdq.push_back(e);
            end else begin
               shadow[addr[win]] = merge(shadow[addr[win]], wen[win], wdata[win]);
            end
         end else begin
            exp_wen = '0;
         end
         wait_h = (req[1] && win != 1) ? wait_h + 1 : 0;
         wait_s = (req[2] && win != 2) ? wait_s + 1 : 0;
      end
      if (reset) begin
         armed = 1;
         rdq.delete();
         wait_h = 0;
         wait_s = 0;
         exp_wen = '0;
         exp_addr = '0;
         exp_wdata = '0;
      end
      cyc++;
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input int p, input logic [7:0] w, input logic [15:0] a,
                        input logic [63:0] d);
      req[p] = 1'b1; wen[p] = w; addr[p] = a; wdata[p] = d;
   endtask

   task automatic idle(input int n);
      req = '0;
      repeat (n) tick();
   endtask

   typedef struct { logic [2:0] req; logic [2:0] gnt; logic [7:0] nxt_wen; } vec_t;
   vec_t tbl [8];

   initial begin
      logic [2:0] seen;
      logic       hv_seen;
      logic [2:0] exp3 [10];
      logic [2:0] exp4 [11];
      int         prob [3];

      tbl[0] = '{3'b000, 3'b000, 8'h00};
      tbl[1] = '{3'b001, 3'b001, 8'h01};
      tbl[2] = '{3'b010, 3'b010, 8'h02};
      tbl[3] = '{3'b011, 3'b001, 8'h01};
      tbl[4] = '{3'b100, 3'b100, 8'h04};
      tbl[5] = '{3'b101, 3'b001, 8'h01};
      tbl[6] = '{3'b110, 3'b010, 8'h02};
      tbl[7] = '{3'b111, 3'b001, 8'h01};

      repeat (3) tick();
      @(negedge clock);
      chk("reset_gnt", gnt, 0);
      chk("reset_mem_wen", mem_wen, 0);
      chk("reset_busy", busy, 0);
      tick();
      reset = 1'b0;
      idle(2);

      // Table: single-cycle request mixes from idle
      for (int i = 0; i < 8; i++) begin
         for (int p = 0; p < 3; p++)
            if (tbl[i].req[p]) drive(p, 8'(1 << p), 16'h0040 + 16'(i), 64'(i * 3 + p));
         @(negedge clock);
         chk($sformatf("tbl%0d_gnt", i), gnt, tbl[i].gnt);
         tick();
         req = '0;
         @(negedge clock);
         chk($sformatf("tbl%0d_mem_wen", i), mem_wen, tbl[i].nxt_wen);
         tick();
      end
      idle(3);

      // Single read from H
      drive(1, 8'h00, 16'h0010, 64'h0);
      @(negedge clock); chk("sr_gnt", gnt, 3'b010);
      tick(); req = '0;
      @(negedge clock); chk("sr_rv_t1", rv, 3'b000);
      tick();
      @(negedge clock); chk("sr_rv_t2", rv, 3'b010); chk("sr_rdata", rdata, 64'h1122334455667788);
      tick();
      @(negedge clock); chk("sr_rv_t3", rv, 3'b000);
      idle(3);

      // Contention: three reads at once
      drive(0, 8'h00, 16'h0001, 64'h0);
      drive(1, 8'h00, 16'h0002, 64'h0);
      drive(2, 8'h00, 16'h0003, 64'h0);
      @(negedge clock); chk("ct_gnt0", gnt, 3'b001);
      tick(); req[0] = 1'b0;
      @(negedge clock); chk("ct_gnt1", gnt, 3'b010);
      tick(); req[1] = 1'b0;
      @(negedge clock); chk("ct_gnt2", gnt, 3'b100);
      chk("ct_rv0", rv, 3'b001); chk("ct_rd0", rdata, fill(1));
      tick(); req[2] = 1'b0;
      @(negedge clock); chk("ct_rv1", rv, 3'b010); chk("ct_rd1", rdata, fill(2));
      tick();
      @(negedge clock); chk("ct_rv2", rv, 3'b100); chk("ct_rd2", rdata, fill(3));
      idle(3);

      // H starved behind continuous C
      for (int k = 0; k < 10; k++) exp3[k] = (k == 8) ? 3'b010 : 3'b001;
      drive(0, 8'hFF, 16'h0020, 64'hC0C0);
      drive(1, 8'hFF, 16'h0021, 64'hA1A1);
      for (int k = 0; k < 10; k++) begin
         @(negedge clock);
         chk($sformatf("sv_gnt%0d", k), gnt, exp3[k]);
         tick();
         if (k == 8) req[1] = 1'b0;
      end
      idle(3);

      // H and S starve together
      for (int k = 0; k < 11; k++) exp4[k] = (k == 8) ? 3'b010 : (k == 9) ? 3'b100 : 3'b001;
      drive(0, 8'hFF, 16'h0022, 64'h1);
      drive(1, 8'hFF, 16'h0023, 64'h2);
      drive(2, 8'hFF, 16'h0024, 64'h3);
      for (int k = 0; k < 11; k++) begin
         @(negedge clock);
         chk($sformatf("bs_gnt%0d", k), gnt, exp4[k]);
         tick();
         if (k == 8) req[1] = 1'b0;
         if (k == 9) req[2] = 1'b0;
      end
      idle(3);

      // Write then read the same word
      hv_seen = 1'b0;
      drive(1, 8'h0F, 16'h0004, 64'h55AA55AA_DEADBEEF);
      @(negedge clock); chk("wr_gnt", gnt, 3'b010); hv_seen |= h_rvalid;
      tick(); req[1] = 1'b0; drive(2, 8'h00, 16'h0004, 64'h0);
      @(negedge clock); chk("wr_rd_gnt", gnt, 3'b100); hv_seen |= h_rvalid;
      tick(); req[2] = 1'b0;
      @(negedge clock); hv_seen |= h_rvalid;
      tick();
      @(negedge clock); hv_seen |= h_rvalid;
      chk("wr_s_rvalid", s_rvalid, 1'b1);
      chk("wr_rdata_lo", rdata[31:0], 32'hDEADBEEF);
      repeat (3) begin tick(); @(negedge clock); hv_seen |= h_rvalid; end
      chk("wr_no_h_rvalid", hv_seen, 1'b0);
      idle(2);

      // Reset one cycle after a read grant
      drive(0, 8'h00, 16'h0005, 64'h0);
      @(negedge clock); chk("rs_gnt", gnt, 3'b001);
      tick(); req = '0; reset = 1'b1; drive(1, 8'h00, 16'h0006, 64'h0);
      @(negedge clock); chk("rs_gnt_in_reset", gnt, 3'b000);
      tick(); reset = 1'b0; req = '0;
      @(negedge clock);
      chk("rs_mem_wen", mem_wen, 8'h00);
      chk("rs_busy", busy, 1'b0);
      chk("rs_rv0", rv, 3'b000);
      tick();
      @(negedge clock); chk("rs_rv1", rv, 3'b000);
      idle(2);

      // Random traffic; the reference model does all the checking
      prob[0] = 70; prob[1] = 40; prob[2] = 40;
      seen = '0;
      for (int n = 0; n < 3000; n++) begin
         reset = ($urandom_range(0, 299) == 0);
         for (int p = 0; p < 3; p++) begin
            if (req[p] && seen[p]) req[p] = 1'b0;
            if (!req[p] && $urandom_range(0, 99) < prob[p]) begin
               drive(p, $urandom_range(0, 1) ? 8'($urandom) : 8'h00,
                     16'($urandom_range(0, 31)), {$urandom, $urandom});
            end
         end
         @(negedge clock);
         seen = gnt;
         tick();
      end
      reset = 1'b0;
      idle(6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
